rf_slot_deser: RTL and testbench

Downstream of `fsm_sync`: converts RF pulse presence per bit slot into framed data words. A slot is the interval between successive `sh_en_sync` strobes (10 000 cycles at 10 MHz nominal). A slot containing an RF pulse is a 1; an empty slot is a 0. The block hunts for a sync pattern, then assembles a WORD_W-bit payload and presents it with a one-cycle valid strobe to the register/readout logic.

---
 rtl/rf_link_pkg.sv | 16 +
 rtl/rf_slot_detector.sv | 36 +++
 rtl/rf_slot_deser.sv | 149 ++++++++++++++
 tb/tb_rf_slot_deser.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_link_pkg.sv
// Shared types and constants for the RF slot link.
// FSM encoding, default sync word and slot timing constants.
package rf_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HUNT    = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  localparam logic [3:0] SYNC_WORD_DEF = 4'b1011;
  localparam int         SLOT_NOM      = 10000;
  localparam int         SLOT_TO_DEF   = 12000;
  localparam logic [1:0] EDGE_SAT      = 2'd2;

endpackage

// File: rtl/rf_slot_detector.sv
// Per-slot RF pulse detector: counts rising edges between strobes.
// slot_bit/slot_multi are valid on the sh_en_sync cycle.
module rf_slot_detector
  import rf_link_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rfin_sync,
  input  logic sh_en_sync,
  output logic slot_bit,
  output logic slot_multi
);

  logic       rf_q;
  logic       rise;
  logic [1:0] cnt;

  assign rise       = rfin_sync & ~rf_q;
  assign slot_bit   = (cnt != 2'd0);
  assign slot_multi = (cnt >= EDGE_SAT);

  // an edge coinciding with the strobe belongs to the next slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_q <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      rf_q <= rfin_sync;
      if (sh_en_sync)
        cnt <= {1'b0, rise};
      else if (rise && cnt != EDGE_SAT)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rf_slot_deser.sv
// Slot deserializer: sync hunt, payload framing, slot timeout.
// Optional even-parity slot after payload: RF_DESER_PARITY_EN.
module rf_slot_deser
  import rf_link_pkg::*;
#(
  parameter int                WORD_W    = 8,
  parameter int                SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int                SLOT_TO   = SLOT_TO_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rfin_sync,
  input  logic                         sh_en_sync,
  input  logic                         locked,
  output logic [WORD_W-1:0]            data_out,
  output logic                         data_valid,
  output logic                         sync_found,
  output logic                         frame_err,
  output logic [$clog2(WORD_W+1)-1:0]  bit_cnt
);

  localparam int CW = $clog2(WORD_W+1);
  localparam int TW = $clog2(SLOT_TO+1);
`ifdef RF_DESER_PARITY_EN
  localparam int NB = WORD_W + 1;
`else
  localparam int NB = WORD_W;
`endif

  state_t            state;
  logic [SYNC_W-1:0] win, win_nxt;
  logic [WORD_W-1:0] pay, pay_nxt;
  logic [TW-1:0]     to_cnt;
  logic              slot_bit, slot_multi;
  logic              to_hit, last, abort;
`ifdef RF_DESER_PARITY_EN
  logic              par;
`endif

  rf_slot_detector u_det (
    .clk        (clk),
    .rst        (rst),
    .rfin_sync  (rfin_sync),
    .sh_en_sync (sh_en_sync),
    .slot_bit   (slot_bit),
    .slot_multi (slot_multi)
  );

  assign win_nxt = {win[SYNC_W-2:0], slot_bit};
  assign pay_nxt = {pay[WORD_W-2:0], slot_bit};
  assign to_hit  = (to_cnt == TW'(SLOT_TO-1));
  assign last    = (bit_cnt == CW'(NB-1));
  // a strobe always wins over a coincident timeout
  assign abort   = (state != ST_IDLE && !sh_en_sync && to_hit)
                 || (state == ST_PAYLOAD && sh_en_sync && slot_multi);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      to_cnt <= '0;
    else if (!locked || state == ST_IDLE || sh_en_sync || to_hit)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      win        <= '0;
      pay        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      sync_found <= 1'b0;
      frame_err  <= 1'b0;
      bit_cnt    <= '0;
`ifdef RF_DESER_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!locked) begin
        state      <= ST_IDLE;
        win        <= '0;
        sync_found <= 1'b0;
        bit_cnt    <= '0;
      end else if (abort) begin
        state      <= ST_HUNT;
        win        <= '0;
        sync_found <= 1'b0;
        bit_cnt    <= '0;
        frame_err  <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            state <= ST_HUNT;
            win   <= '0;
          end
          ST_HUNT: begin
            if (sh_en_sync) begin
              win <= win_nxt;
              if (win_nxt == SYNC_WORD) begin
                state      <= ST_PAYLOAD;
                sync_found <= 1'b1;
                bit_cnt    <= '0;
`ifdef RF_DESER_PARITY_EN
                par        <= 1'b0;
`endif
              end
            end
          end
          ST_PAYLOAD: begin
            if (sh_en_sync) begin
              bit_cnt <= bit_cnt + 1'b1;
`ifdef RF_DESER_PARITY_EN
              if (!last) begin
                pay <= pay_nxt;
                par <= par ^ slot_bit;
              end else begin
                state      <= ST_HUNT;
                win        <= '0;
                sync_found <= 1'b0;
                if (par == slot_bit) begin
                  data_out   <= pay;
                  data_valid <= 1'b1;
                end else begin
                  frame_err  <= 1'b1;
                end
              end
`else
              pay <= pay_nxt;
              if (last) begin
                state      <= ST_HUNT;
                win        <= '0;
                sync_found <= 1'b0;
                data_out   <= pay_nxt;
                data_valid <= 1'b1;
              end
`endif
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rf_slot_deser.sv
// Self-checking bench for rf_slot_deser with a queue-based frame model.
// Honours RF_DESER_PARITY_EN when the design is built with it.
module tb_rf_slot_deser;

  localparam int SLOT_TO = 12000;
  localparam int SL      = 16;
`ifdef RF_DESER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rfin_sync = 1'b0;
  logic       sh_en_sync = 1'b0;
  logic       locked = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, sync_found, frame_err;
  logic [3:0] bit_cnt;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_slot_deser #(
    .WORD_W    (8),
    .SYNC_W    (4),
    .SYNC_WORD (4'b1011),
    .SLOT_TO   (SLOT_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rfin_sync  (rfin_sync),
    .sh_en_sync (sh_en_sync),
    .locked     (locked),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sync_found (sync_found),
    .frame_err  (frame_err),
    .bit_cnt    (bit_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---- behavioural model: slots as bit lists, frames as queues ----
  bit         m_active, m_inframe, m_prev;
  int         m_edges, m_gap, hunt;
  bit         pay[$];
  logic [7:0] e_data;
  logic       e_valid, e_err, e_sync;
  int         e_cnt;

  task m_abort();
    e_err     = 1'b1;
    m_inframe = 1'b0;
    hunt      = 0;
    pay.delete();
  endtask

  task m_close();
    logic [7:0] d;
    bit p;
    d = '0;
    p = 1'b0;
    for (int i = 0; i < 8; i++) d = {d[6:0], pay[i]};
    for (int i = 0; i < pay.size(); i++) p ^= pay[i];
    m_inframe = 1'b0;
    hunt = 0;
    if (NB == 8 || p == 1'b0) begin
      e_data  = d;
      e_valid = 1'b1;
    end else begin
      e_err = 1'b1;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 0; m_inframe = 0; m_prev = 0;
      m_edges = 0; m_gap = 0; hunt = 0;
      pay.delete();
      e_data = '0; e_valid = 0; e_err = 0; e_sync = 0; e_cnt = 0;
    end else begin
      bit rise, sb, mb, stb;
      rise = rfin_sync && !m_prev;
      m_prev = rfin_sync;
      stb = sh_en_sync;
      sb = (m_edges >= 1);
      mb = (m_edges >= 2);
      if (stb) m_edges = rise;
      else m_edges = m_edges + rise;
      e_valid = 0;
      e_err = 0;
      if (!locked) begin
        m_active = 0; m_inframe = 0; hunt = 0; m_gap = 0;
        pay.delete();
      end else if (!m_active) begin
        m_active = 1; hunt = 0; m_gap = 0;
      end else begin
        m_gap = stb ? 0 : m_gap + 1;
        if (!stb && m_gap >= SLOT_TO) begin
          m_abort();
          m_gap = 0;
        end else if (stb && !m_inframe) begin
          hunt = ((hunt << 1) | sb) & 'hF;
          if (hunt == 'hB) begin
            m_inframe = 1;
            pay.delete();
          end
        end else if (stb) begin
          if (mb) m_abort();
          else begin
            pay.push_back(sb);
            if (pay.size() == NB) m_close();
          end
        end
      end
      e_sync = m_inframe;
      e_cnt = pay.size();
    end
  end

  always @(negedge clk) begin
    chk("data_out", data_out, e_data);
    chk("data_valid", data_valid, e_valid);
    chk("frame_err", frame_err, e_err);
    chk("sync_found", sync_found, e_sync);
    chk("bit_cnt", bit_cnt, e_cnt);
    n_valid += data_valid;
    n_err += frame_err;
  end

  // ---- stimulus ----
  task automatic slot(input int np, input bit at_stb = 1'b0);
    for (int c = 0; c < SL; c++) begin
      @(negedge clk);
      rfin_sync  = ((c % 2 == 1) && c < 2*np) || (at_stb && c == SL-1);
      sh_en_sync = (c == SL-1);
    end
    @(negedge clk);
    rfin_sync  = 1'b0;
    sh_en_sync = 1'b0;
  endtask

  task automatic sync_pat();
    slot(1); slot(0); slot(1); slot(1);
  endtask

  task automatic send_bits(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) slot(int'(d[i]));
  endtask

  task automatic frame(input logic [7:0] d);
    sync_pat();
    send_bits(d);
`ifdef RF_DESER_PARITY_EN
    slot(int'(^d));
`endif
  endtask

  initial begin
    int n0, v0;
    repeat (3) @(negedge clk);
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_sync", sync_found, 1'b0);
    chk("rst_cnt", bit_cnt, 4'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    locked = 1'b1;
    repeat (3) @(negedge clk);

    frame(8'hA6);
    chk("t1_valid", data_valid, 1'b1);
    chk("t1_data", data_out, 8'hA6);
    chk("t1_model", e_data, 8'hA6);
    chk("t1_cnt", bit_cnt, NB);
    chk("t1_noerr", n_err, 0);

    sync_pat();
    slot(1); slot(0); slot(2);
    chk("t2_err", frame_err, 1'b1);
    chk("t2_model_err", e_err, 1'b1);
    chk("t2_sync", sync_found, 1'b0);
    chk("t2_novalid", data_valid, 1'b0);
    frame(8'hFF);
    chk("t2_data", data_out, 8'hFF);
    chk("t2_valid", data_valid, 1'b1);
    @(negedge clk);
    chk("t2_nvalid", n_valid, 2);

    sync_pat();
    slot(1); slot(1); slot(0);
    chk("t3_insync", sync_found, 1'b1);
    n0 = n_err;
    repeat (SLOT_TO + 1) @(negedge clk);
    chk("t3_err_cnt", n_err - n0, 1);
    chk("t3_sync", sync_found, 1'b0);
    chk("t3_cnt", bit_cnt, 4'd0);

    sync_pat();
    slot(1); slot(0);
    repeat (5) @(negedge clk);
    n0 = n_err;
    v0 = n_valid;
    locked = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_data", data_out, 8'hFF);
    chk("t4_noerr", n_err - n0, 0);
    chk("t4_novalid", n_valid - v0, 0);
    chk("t4_sync", sync_found, 1'b0);
    locked = 1'b1;
    repeat (3) @(negedge clk);
    frame(8'h5A);
    chk("t4_data2", data_out, 8'h5A);
    chk("t4_valid2", data_valid, 1'b1);

    sync_pat();
    slot(0, 1'b1);
    slot(0);
    repeat (6) slot(0);
`ifdef RF_DESER_PARITY_EN
    slot(1);
`endif
    chk("t5_data", data_out, 8'h40);
    chk("t5_valid", data_valid, 1'b1);

    sync_pat();
    slot(1); slot(1);
    chk("t6_pre_cnt", bit_cnt, 4'd2);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t6_data", data_out, 8'h00);
    chk("t6_sync", sync_found, 1'b0);
    chk("t6_cnt", bit_cnt, 4'd0);
    chk("t6_valid", data_valid, 1'b0);
    chk("t6_err", frame_err, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

`ifdef RF_DESER_PARITY_EN
    sync_pat();
    send_bits(8'h03);
    slot(1);
    chk("t7_err", frame_err, 1'b1);
    chk("t7_novalid", data_valid, 1'b0);
    chk("t7_data", data_out, 8'h00);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
